// File: rtl/vregfile_scalar_arb.sv
// vregfile_scalar_arb: arbiter and sequencer for the vector unit's scalar
// register file. The file has one synchronous read port (a) and one write
// port (c). A mixed-port collision on the RAM returns the old data.
//  - Reads: rd0 and rd1 share port a under round-robin. Latency is 1 cycle.
//  - Writes: wr0 and wr1 share port c. wr0 always has priority.
//  - Register 0 reads as zero. Writes to register 0 are acked and then dropped.
// Optional feature: define VREGFILE_SCALAR_ARB_BYPASS_EN to forward the write
// data on a same-cycle read/write collision. Without it, a reader that
// collides with the accepted write is masked for that cycle and retries.
module vregfile_scalar_arb #(
  parameter int WIDTH       = 32,
  parameter int LOG2NUMREGS = 5
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   rd0_req,
  input  logic [LOG2NUMREGS-1:0] rd0_reg,
  output logic                   rd0_grant,
  input  logic                   rd1_req,
  input  logic [LOG2NUMREGS-1:0] rd1_reg,
  output logic                   rd1_grant,
  output logic                   rd_valid,
  output logic                   rd_id,
  output logic [WIDTH-1:0]       rd_data,
  input  logic                   wr0_req,
  input  logic [LOG2NUMREGS-1:0] wr0_reg,
  input  logic [WIDTH-1:0]       wr0_data,
  output logic                   wr0_ack,
  input  logic                   wr1_req,
  input  logic [LOG2NUMREGS-1:0] wr1_reg,
  input  logic [WIDTH-1:0]       wr1_data,
  output logic                   wr1_ack,
  output logic [LOG2NUMREGS-1:0] a_reg,
  output logic                   a_en,
  input  logic [WIDTH-1:0]       a_readdataout,
  output logic [LOG2NUMREGS-1:0] c_reg,
  output logic [WIDTH-1:0]       c_writedatain,
  output logic                   c_we
);

  logic                   wr_live;   // accepted write that really lands
  logic                   rr_ptr;    // winner of the next read tie
  logic                   elig0, elig1;
  logic                   gnt_any;
  logic [LOG2NUMREGS-1:0] gnt_idx;
  logic [LOG2NUMREGS-1:0] a_reg_q;   // last driven read address
  logic                   rd_zero;   // in-flight read targets register 0

  // Fixed-priority write select. Register 0 writes are acked but never hit the RAM.
  always_comb begin
    wr0_ack       = wr0_req;
    wr1_ack       = wr1_req & ~wr0_req;
    c_reg         = wr0_req ? wr0_reg  : wr1_reg;
    c_writedatain = wr0_req ? wr0_data : wr1_data;
    wr_live       = (wr0_req | wr1_req) & (c_reg != '0);
    c_we          = wr_live;
  end

  // Round-robin read grant. The port address holds its value when nobody is granted.
  always_comb begin
`ifdef VREGFILE_SCALAR_ARB_BYPASS_EN
    elig0 = rd0_req;
    elig1 = rd1_req;
`else
    // A reader that hits this cycle's write is held off until the next cycle.
    // By then the RAM has the new value.
    elig0 = rd0_req & ~(wr_live & (rd0_reg == c_reg));
    elig1 = rd1_req & ~(wr_live & (rd1_reg == c_reg));
`endif
    rd0_grant = elig0 & (~elig1 | ~rr_ptr);
    rd1_grant = elig1 & (~elig0 |  rr_ptr);
    gnt_any   = rd0_grant | rd1_grant;
    gnt_idx   = rd1_grant ? rd1_reg : rd0_reg;
    a_en      = gnt_any;
    a_reg     = gnt_any ? gnt_idx : a_reg_q;
  end

  // Read pipeline state. After a grant the loser becomes the next tie winner.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr   <= 1'b0;
      rd_valid <= 1'b0;
      rd_id    <= 1'b0;
      rd_zero  <= 1'b0;
      a_reg_q  <= '0;
    end else begin
      rd_valid <= gnt_any;
      if (gnt_any) begin
        rr_ptr  <= rd0_grant;
        rd_id   <= rd1_grant;
        rd_zero <= (gnt_idx == '0);
        a_reg_q <= gnt_idx;
      end
    end
  end

`ifdef VREGFILE_SCALAR_ARB_BYPASS_EN
  logic             byp_hit;
  logic [WIDTH-1:0] byp_data;

  // Capture the write data when the granted read collides with the landing write.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else if (gnt_any) begin
      byp_hit  <= wr_live & (gnt_idx == c_reg);
      byp_data <= c_writedatain;
    end
  end
`endif

  // Result mux: zero when idle or for register 0, else forwarded or RAM data.
  always_comb begin
    rd_data = '0;
    if (rd_valid && !rd_zero) begin
      rd_data = a_readdataout;
`ifdef VREGFILE_SCALAR_ARB_BYPASS_EN
      if (byp_hit) rd_data = byp_data;
`endif
    end
  end

endmodule

// File: tb/tb_vregfile_scalar_arb.sv
// Self-checking bench for vregfile_scalar_arb. It holds two things:
//  - a register-file RAM with synchronous read and old-data on collision;
//  - an architectural reference model built from the arbitration rules.
//    In the model, a read observes every write accepted up to and including
//    its own grant cycle.
module tb_vregfile_scalar_arb;
  localparam int W = 32;
  localparam int L = 5;

  logic         clk = 1'b0;
  logic         resetn;
  logic         rd0_req, rd1_req, rd0_grant, rd1_grant;
  logic [L-1:0] rd0_reg, rd1_reg;
  logic         rd_valid, rd_id;
  logic [W-1:0] rd_data;
  logic         wr0_req, wr1_req, wr0_ack, wr1_ack;
  logic [L-1:0] wr0_reg, wr1_reg;
  logic [W-1:0] wr0_data, wr1_data;
  logic [L-1:0] a_reg, c_reg;
  logic         a_en, c_we;
  logic [W-1:0] a_readdataout, c_writedatain;

  vregfile_scalar_arb #(.WIDTH(W), .LOG2NUMREGS(L)) dut (
    .clk(clk), .resetn(resetn),
    .rd0_req(rd0_req), .rd0_reg(rd0_reg), .rd0_grant(rd0_grant),
    .rd1_req(rd1_req), .rd1_reg(rd1_reg), .rd1_grant(rd1_grant),
    .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
    .wr0_req(wr0_req), .wr0_reg(wr0_reg), .wr0_data(wr0_data), .wr0_ack(wr0_ack),
    .wr1_req(wr1_req), .wr1_reg(wr1_reg), .wr1_data(wr1_data), .wr1_ack(wr1_ack),
    .a_reg(a_reg), .a_en(a_en), .a_readdataout(a_readdataout),
    .c_reg(c_reg), .c_writedatain(c_writedatain), .c_we(c_we)
  );

  always #5 clk = ~clk;

  // Register file RAM: synchronous read, old data on read/write collision.
  logic [W-1:0] ram [0:31];
  logic         pl_en = 1'b0;
  logic [L-1:0] pl_idx = '0;
  logic [W-1:0] pl_dat = '0;
  always @(posedge clk) begin
    if (a_en) a_readdataout <= ram[a_reg];
    if (c_we) ram[c_reg] <= c_writedatain;
    if (pl_en) ram[pl_idx] <= pl_dat;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Reference model state.
  logic [W-1:0] arch [0:31];
  logic         m_ptr = 1'b0;
  logic         m_vld = 1'b0;
  logic         m_id = 1'b0;
  logic [W-1:0] m_data = '0;
  logic [L-1:0] m_last = '0;
  logic         m_last_ok = 1'b0;

  // One clock: drive inputs, check combinational and registered outputs, then advance the model.
  task automatic cyc(input logic rst_n,
                     input logic r0q, input logic [L-1:0] r0r,
                     input logic r1q, input logic [L-1:0] r1r,
                     input logic w0q, input logic [L-1:0] w0r, input logic [W-1:0] w0d,
                     input logic w1q, input logic [L-1:0] w1r, input logic [W-1:0] w1d);
    logic         wacc, wland, e0, e1, g0, g1;
    logic [L-1:0] widx, gidx;
    logic [W-1:0] wdat;
    @(negedge clk);
    resetn = rst_n;
    rd0_req = r0q; rd0_reg = r0r; rd1_req = r1q; rd1_reg = r1r;
    wr0_req = w0q; wr0_reg = w0r; wr0_data = w0d;
    wr1_req = w1q; wr1_reg = w1r; wr1_data = w1d;
    #1;
    wacc  = w0q | w1q;
    widx  = w0q ? w0r : w1r;
    wdat  = w0q ? w0d : w1d;
    wland = wacc && widx != 0;
    e0 = r0q;
    e1 = r1q;
`ifndef VREGFILE_SCALAR_ARB_BYPASS_EN
    if (wland && r0r == widx) e0 = 1'b0;
    if (wland && r1r == widx) e1 = 1'b0;
`endif
    if (e0 && e1) begin
      g0 = (m_ptr == 1'b0);
      g1 = !g0;
    end else begin
      g0 = e0;
      g1 = e1;
    end
    gidx = g1 ? r1r : r0r;
    chk("rd0_grant", {31'd0, rd0_grant}, {31'd0, g0});
    chk("rd1_grant", {31'd0, rd1_grant}, {31'd0, g1});
    chk("wr0_ack", {31'd0, wr0_ack}, {31'd0, w0q});
    chk("wr1_ack", {31'd0, wr1_ack}, {31'd0, w1q & ~w0q});
    chk("c_we", {31'd0, c_we}, {31'd0, wland});
    if (wacc) begin
      chk("c_reg", {27'd0, c_reg}, {27'd0, widx});
      chk("c_wdata", c_writedatain, wdat);
    end
    chk("a_en", {31'd0, a_en}, {31'd0, g0 | g1});
    if (g0 | g1) chk("a_reg", {27'd0, a_reg}, {27'd0, gidx});
    else if (m_last_ok) chk("a_reg_hold", {27'd0, a_reg}, {27'd0, m_last});
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_vld});
    if (m_vld) chk("rd_id", {31'd0, rd_id}, {31'd0, m_id});
    chk("rd_data", rd_data, m_vld ? m_data : 32'd0);
    @(posedge clk);
    if (wland) arch[widx] = wdat;
    if (!rst_n) begin
      m_vld = 1'b0;
      m_ptr = 1'b0;
      m_last_ok = 1'b0;
    end else if (g0 | g1) begin
      m_vld = 1'b1;
      m_id = g1;
      m_data = (gidx == 0) ? 32'd0 : arch[gidx];
      m_ptr = g0;
      m_last = gidx;
      m_last_ok = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
  endtask

  task automatic idle(input logic rst_n);
    cyc(rst_n, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic         p1, p1_keep;
  logic [L-1:0] p1_reg;
  logic [W-1:0] p1_dat;

  initial begin
    resetn = 1'b0;
    rd0_req = 0; rd1_req = 0; wr0_req = 0; wr1_req = 0;
    rd0_reg = 0; rd1_reg = 0; wr0_reg = 0; wr1_reg = 0;
    wr0_data = 0; wr1_data = 0;
    // Preload registers 0..7 while in reset. The RAM location for register 0 holds garbage.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pl_en = 1'b1;
      pl_idx = L'(i);
      case (i)
        0: pl_dat = 32'h5555AAAA;
        5: pl_dat = 32'hDEADBEEF;
        7: pl_dat = 32'hAAAA0000;
        default: pl_dat = $urandom;
      endcase
      arch[i] = pl_dat;
      @(posedge clk);
    end
    @(negedge clk);
    pl_en = 1'b0;
    idle(1'b0);
    #1 chk("reset_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset_data", rd_data, 32'd0);

    // Single read of register 5.
    cyc(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("rd5_data", rd_data, 32'hDEADBEEF);
    chk("rd5_id", {31'd0, rd_id}, 32'd0);

    // Tie from reset: the grants alternate.
    idle(1'b0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    idle(1'b1);

    // Write priority: wr1 waits one cycle.
    cyc(1, 0, 0, 0, 0, 1, 3, 32'h11, 1, 4, 32'h22);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h22);
    cyc(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("rd3_data", rd_data, 32'h11);
    cyc(1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0);
    #1 chk("rd4_data", rd_data, 32'h22);

    // Write to register 0 is dropped, and register 0 reads as zero.
    cyc(1, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("rd0_zero", rd_data, 32'd0);

    // Same-cycle collision on register 7, then a retry.
    cyc(1, 0, 0, 1, 7, 1, 7, 32'h12345678, 0, 0, 0);
    cyc(1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0);
    #1 chk("coll_data", rd_data, 32'h12345678);
    idle(1'b1);

    // Reset right after a grant discards the result and clears the pointer.
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1'b0);
    #1 chk("rst_mid_valid", {31'd0, rd_valid}, 32'd0);
    cyc(1, 1, 2, 1, 3, 0, 0, 0, 0, 0, 0);
    idle(1'b1);

    // Random traffic. An unacked wr1 keeps its request unchanged.
    p1_keep = 1'b0; p1 = 1'b0; p1_reg = '0; p1_dat = '0;
    for (int k = 0; k < 600; k++) begin
      logic         a0q, a1q, b0q;
      logic [L-1:0] a0r, a1r, b0r;
      logic [W-1:0] b0d;
      a0q = ($urandom_range(3) != 0);
      a1q = ($urandom_range(3) != 0);
      a0r = L'($urandom_range(7));
      a1r = L'($urandom_range(7));
      b0q = ($urandom_range(2) == 0);
      b0r = L'($urandom_range(7));
      b0d = $urandom;
      if (!p1_keep) begin
        p1 = ($urandom_range(2) == 0);
        p1_reg = L'($urandom_range(7));
        p1_dat = $urandom;
      end
      cyc(1, a0q, a0r, a1q, a1r, b0q, b0r, b0d, p1, p1_reg, p1_dat);
      p1_keep = p1 & b0q;
    end
    idle(1'b1);
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
